// File: rtl/dmem_responder.sv
// MEM-stage data port responder: word RAM plus an MMIO block holding a cycle
// counter, a FIFO status word and a debug output FIFO drained by a ready/valid sink.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] ddata_r,
  output logic [31:0] dbg_data,
  output logic        dbg_valid,
  input  logic        dbg_ready,
  output logic        bad_access
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_LIM  = 32'(DEPTH_WORDS * 4);
  localparam logic [31:0] CNT_ADR  = MMIO_BASE;
  localparam logic [31:0] PUSH_ADR = MMIO_BASE + 32'h4;
  localparam logic [31:0] STAT_ADR = MMIO_BASE + 32'h8;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   fifo_mem [FIFO_DEPTH];

  logic [31:0]   cnt_reg;
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [4:0]    count_reg, count_next;
  logic          overflow_reg, overflow_next;
  logic          bad_access_reg, bad_access_next;

  logic          is_ram, is_cnt, is_push, is_stat, is_unmapped;
  logic [AW-1:0] ram_idx;
  logic          full, empty, pop, push_req, push_ok;
  logic [31:0]   status_word;

  // MMIO decode ignores the byte-offset bits, just like the RAM index does.
  always_comb begin
    is_ram      = (daddr < RAM_LIM);
    is_cnt      = (daddr[31:2] == CNT_ADR[31:2]);
    is_push     = (daddr[31:2] == PUSH_ADR[31:2]);
    is_stat     = (daddr[31:2] == STAT_ADR[31:2]);
    is_unmapped = !(is_ram || is_cnt || is_push || is_stat);
    ram_idx     = daddr[AW+1:2];
  end

  always_comb begin
    full        = (count_reg == 5'(FIFO_DEPTH));
    empty       = (count_reg == 5'd0);
    pop         = !empty && dbg_ready;
    push_req    = d_w && is_push;
    push_ok     = push_req && (!full || pop);
    status_word = {23'd0, count_reg, 1'b0, overflow_reg, empty, full};
  end

  always_comb begin
    count_next      = count_reg + {4'd0, push_ok} - {4'd0, pop};
    overflow_next   = overflow_reg || (push_req && full && !pop);
    bad_access_next = bad_access_reg || ((d_r || d_w) && is_unmapped);
  end

  always_comb begin
    ddata_r = 32'd0;
    if (d_r) begin
      if (is_ram)       ddata_r = mem[ram_idx];
      else if (is_cnt)  ddata_r = cnt_reg;
      else if (is_stat) ddata_r = status_word;
    end
  end

  assign dbg_valid  = !empty;
  assign dbg_data   = empty ? 32'd0 : fifo_mem[rd_ptr_reg];
  assign bad_access = bad_access_reg;

  // RAM contents survive reset; only the write is suppressed.
  always_ff @(posedge CLK) begin
    if (RESET_N && d_w && is_ram)
      mem[ram_idx] <= ddata_w;
  end

  always_ff @(posedge CLK) begin
    if (RESET_N && push_ok)
      fifo_mem[wr_ptr_reg] <= ddata_w;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_reg        <= 32'd0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= 5'd0;
      overflow_reg   <= 1'b0;
      bad_access_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_reg + 32'd1;
      count_reg      <= count_next;
      overflow_reg   <= overflow_next;
      bad_access_reg <= bad_access_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized bench for dmem_responder against a queue/array
// reference model of the memory map.
module tb_dmem_responder;

  localparam int          DW   = 1024;
  localparam int          FD   = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [31:0] daddr = 32'd0;
  logic [31:0] ddata_w = 32'd0;
  logic        d_w = 1'b0;
  logic        d_r = 1'b0;
  logic        dbg_ready = 1'b0;
  logic [31:0] ddata_r;
  logic [31:0] dbg_data;
  logic        dbg_valid;
  logic        bad_access;

  dmem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD), .MMIO_BASE(BASE)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .daddr(daddr), .ddata_w(ddata_w),
    .d_w(d_w), .d_r(d_r), .ddata_r(ddata_r), .dbg_data(dbg_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .bad_access(bad_access)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  // reference model state
  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_q [$];
  logic [31:0] m_cnt = 32'd0;
  logic        m_ovf = 1'b0;
  logic        m_bad = 1'b0;

  // values observed in the last step
  logic [31:0] o_rd, o_data;
  logic        o_valid, o_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic bit is_mapped(input logic [31:0] a);
    return (a < DW * 4) || a == BASE || a == BASE + 4 || a == BASE + 8;
  endfunction

  function automatic logic [31:0] m_status();
    int n = m_q.size();
    return {23'd0, 5'(n), 1'b0, m_ovf, n == 0, n == FD};
  endfunction

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input bit w,
                      input bit r, input bit rdy, input bit rst_n);
    logic [31:0] wa;
    logic [31:0] exp_rd;
    bit          rd_known;
    bit          full_b, popd;
    wa = a & 32'hFFFF_FFFC;
    daddr = a; ddata_w = wd; d_w = w; d_r = r; dbg_ready = rdy; RESET_N = rst_n;
    @(negedge CLK);
    rd_known = 1'b1;
    exp_rd   = 32'd0;
    if (r) begin
      if (wa < DW * 4) begin
        if (m_ram.exists(wa >> 2)) exp_rd = m_ram[wa >> 2];
        else rd_known = 1'b0;
      end else if (wa == BASE)     exp_rd = m_cnt;
      else if (wa == BASE + 8)     exp_rd = m_status();
    end
    o_rd = ddata_r; o_data = dbg_data; o_valid = dbg_valid; o_bad = bad_access;
    $display("step %0d addr=%08h wd=%08h w=%0d r=%0d rdy=%0d rst_n=%0d rd=%08h valid=%0d data=%08h bad=%0d",
             step_no, a, wd, w, r, rdy, rst_n, o_rd, o_valid, o_data, o_bad);
    if (rd_known) check("ddata_r", o_rd, exp_rd);
    check("dbg_valid", {31'd0, o_valid}, {31'd0, m_q.size() != 0});
    check("dbg_data", o_data, (m_q.size() != 0) ? m_q[0] : 32'd0);
    check("bad_access", {31'd0, o_bad}, {31'd0, m_bad});
    @(posedge CLK);
    if (!rst_n) begin
      m_cnt = 32'd0; m_q.delete(); m_ovf = 1'b0; m_bad = 1'b0;
    end else begin
      full_b = (m_q.size() == FD);
      popd   = (m_q.size() != 0) && rdy;
      if (w && wa < DW * 4) m_ram[wa >> 2] = wd;
      if (popd) void'(m_q.pop_front());
      if (w && wa == BASE + 4) begin
        if (!full_b || popd) m_q.push_back(wd);
        else m_ovf = 1'b1;
      end
      if ((w || r) && !is_mapped(wa)) m_bad = 1'b1;
      m_cnt = m_cnt + 32'd1;
    end
    step_no++;
    #1;
  endtask

  task automatic idle(input bit rdy);
    step(32'd0, 32'd0, 1'b0, 1'b0, rdy, 1'b1);
  endtask

  initial begin
    logic [31:0] a, wd;
    bit          w, r, rdy, rst_n;
    int          sel;

    @(posedge CLK);
    #1;

    // reset and counter
    step(BASE, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(BASE, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("cnt_after_reset", o_rd, 32'd0);
    check("valid_after_reset", {31'd0, o_valid}, 32'd0);
    check("bad_after_reset", {31'd0, o_bad}, 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b0);
    step(BASE, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("cnt_at_5", o_rd, 32'd5);

    // RAM write, offset-ignoring read, read-before-write
    step(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ram_rd_10", o_rd, 32'hDEAD_BEEF);
    step(32'h12, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ram_rd_12", o_rd, 32'hDEAD_BEEF);
    step(32'h10, 32'hCAFE_F00D, 1'b1, 1'b1, 1'b0, 1'b1);
    check("ram_rbw_old", o_rd, 32'hDEAD_BEEF);
    step(32'h10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("ram_rbw_new", o_rd, 32'hCAFE_F00D);

    // overflow then drain
    for (int i = 1; i <= 5; i++) step(BASE + 4, 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    step(BASE + 8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("status_full_ovf", o_rd, 32'h0000_0045);
    for (int i = 1; i <= 4; i++) begin
      idle(1'b1);
      check("drain_data", o_data, 32'(i));
    end
    step(BASE + 8, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    check("status_empty", o_rd, 32'h0000_0006);
    check("drain_valid", {31'd0, o_valid}, 32'd0);

    // push into a full FIFO while it pops
    step(32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) step(BASE + 4, 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    step(BASE + 4, 32'hAA, 1'b1, 1'b0, 1'b1, 1'b1);
    step(BASE + 8, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("status_full_no_ovf", o_rd, 32'h0000_0041);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("drain_after_pp", o_data, (i == 3) ? 32'hAA : 32'(i + 2));
    end

    // unmapped access and ignored CNT write
    step(32'h4000_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("unmapped_rd", o_rd, 32'd0);
    step(BASE, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b1);
    check("bad_set", {31'd0, o_bad}, 32'd1);
    step(BASE, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("bad_held", {31'd0, o_bad}, 32'd1);

    // reset mid-stream with a suppressed RAM write
    step(32'h20, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(BASE + 4, 32'h50 + 32'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    step(32'h20, 32'h9999_9999, 1'b1, 1'b0, 1'b0, 1'b0);
    step(BASE, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_cnt", o_rd, 32'd0);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_bad", {31'd0, o_bad}, 32'd0);
    step(32'h20, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_ram_kept_20", o_rd, 32'h1111_2222);
    step(32'h10, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("rst_ram_kept_10", o_rd, 32'hCAFE_F00D);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      sel = $urandom_range(0, 19);
      wd  = $urandom;
      w   = $urandom_range(0, 1);
      r   = $urandom_range(0, 1);
      rdy = ($urandom_range(0, 2) != 0);
      rst_n = ($urandom_range(0, 59) != 0);
      if (sel < 6)       a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else if (sel < 8)  a = BASE + 32'($urandom_range(0, 3));
      else if (sel < 14) a = BASE + 4;
      else if (sel < 18) a = BASE + 8 + 32'($urandom_range(0, 3));
      else if (sel < 19) a = 32'(DW * 4) + 32'($urandom_range(0, 255));
      else               a = BASE + 32'h10 + 32'($urandom_range(0, 1023));
      if (sel < 18 || $urandom_range(0, 3) == 0) step(a, wd, w, r, rdy, rst_n);
      else idle(rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
